// File: rtl/seq_mult_div.sv
// seq_mult_div: iterative signed multiply/divide unit for the HI/LO registers.
// One shared 2*WIDTH shift datapath runs on operand magnitudes for WIDTH
// iterations, then a fix-up step restores the signs.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   start         begin an operation (sampled only while idle)
//   op            0 = signed multiply, 1 = signed divide
//   a, b          multiplicand/dividend and multiplier/divisor, captured at start
//   busy          high while the operation is iterating or fixing up signs
//   done          one-cycle pulse; hi/lo/flags valid from this cycle on
//   hi, lo        multiply: product[2W-1:W] / product[W-1:0];
//                 divide: remainder / quotient
//   div_by_zero   divide with b == 0 (hi/lo keep their previous values)
//   mult_overflow product does not fit in signed WIDTH bits
module seq_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             mult_overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT state;

  // acc: multiply {partial product, remaining multiplier}; divide {rem, quot}
  logic [2*WIDTH-1:0] acc;
  // magnitude of the multiplicand (multiply) or divisor (divide)
  logic [WIDTH-1:0]   operand;
  logic               signA;
  logic               signB;
  logic               opReg;
  logic               dbzPend;
  logic [CW-1:0]      counter;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulStep;
  logic [2*WIDTH-1:0] divShift;
  logic [2*WIDTH-1:0] divStep;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  // Operand magnitudes, one iteration of each algorithm, and sign fix-up values
  always_comb begin
    absA     = a;
    absB     = b;
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]};
    mulStep  = acc;
    divShift = {acc[2*WIDTH-2:0], 1'b0};
    divStep  = divShift;
    prodFix  = acc;
    quotFix  = acc[WIDTH-1:0];
    remFix   = acc[2*WIDTH-1:WIDTH];

    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    if (a[WIDTH-1]) begin
      absA = (~a) + WIDTH'(1);
    end else begin
      absA = a;
    end
    if (b[WIDTH-1]) begin
      absB = (~b) + WIDTH'(1);
    end else begin
      absB = b;
    end

    // Shift-add: the carry out of the upper half becomes the new top bit.
    if (acc[0]) begin
      mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    end else begin
      mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    end
    mulStep = {mulSum, acc[WIDTH-1:1]};

    // Restoring division: the remainder is always below the divisor, so the
    // left shift never loses a set bit.
    if (divShift[2*WIDTH-1:WIDTH] >= operand) begin
      divStep = {divShift[2*WIDTH-1:WIDTH] - operand, divShift[WIDTH-1:1], 1'b1};
    end else begin
      divStep = divShift;
    end

    if (signA ^ signB) begin
      prodFix = (~acc) + (2*WIDTH)'(1);
      quotFix = (~acc[WIDTH-1:0]) + WIDTH'(1);
    end else begin
      prodFix = acc;
      quotFix = acc[WIDTH-1:0];
    end
    if (signA) begin
      remFix = (~acc[2*WIDTH-1:WIDTH]) + WIDTH'(1);
    end else begin
      remFix = acc[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM and all registered state/outputs. FIX leaves the signed
  // result in acc; DONE copies it into hi/lo so they only change on the
  // edge that raises done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      operand       <= '0;
      signA         <= 1'b0;
      signB         <= 1'b0;
      opReg         <= 1'b0;
      dbzPend       <= 1'b0;
      counter       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      hi            <= '0;
      lo            <= '0;
      div_by_zero   <= 1'b0;
      mult_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            signA         <= a[WIDTH-1];
            signB         <= b[WIDTH-1];
            opReg         <= op;
            counter       <= '0;
            div_by_zero   <= 1'b0;
            mult_overflow <= 1'b0;
            if (op) begin
              operand <= absB;
              acc     <= {{WIDTH{1'b0}}, absA};
            end else begin
              operand <= absA;
              acc     <= {{WIDTH{1'b0}}, absB};
            end
            if (op && (b == '0)) begin
              dbzPend <= 1'b1;
              state   <= DONE;
            end else begin
              dbzPend <= 1'b0;
              busy    <= 1'b1;
              state   <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (opReg) begin
            acc <= divStep;
          end else begin
            acc <= mulStep;
          end
          counter <= counter + CW'(1);
          if (counter == CW'(WIDTH - 1)) begin
            state <= FIX;
          end else begin
            state <= RUN;
          end
        end
        FIX: begin
          if (opReg) begin
            acc <= {remFix, quotFix};
          end else begin
            acc <= prodFix;
          end
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
          if (dbzPend) begin
            div_by_zero <= 1'b1;
          end else begin
            hi            <= acc[2*WIDTH-1:WIDTH];
            lo            <= acc[WIDTH-1:0];
            mult_overflow <= !opReg && (acc[2*WIDTH-1:WIDTH] != {WIDTH{acc[WIDTH-1]}});
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_div.sv
// Directed self-checking bench for seq_mult_div (WIDTH = 32).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_seq_mult_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;
  logic        mult_overflow;

  int passCount  = 0;
  int totalCount = 0;
  int lat;
  int busyCycles;
  int doneCount;

  seq_mult_div #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo),
    .div_by_zero(div_by_zero),
    .mult_overflow(mult_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one operation and wait (bounded) for done. lat counts clock edges
  // after the accepting edge; busyCycles counts busy-high sample points.
  task automatic runOp(input logic opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                       output int latOut, output int busyOut);
    @(negedge clk);
    start = 1'b1;
    op    = opIn;
    a     = aIn;
    b     = bIn;
    @(negedge clk);
    start = 1'b0;
    a     = 32'hDEADBEEF;
    b     = 32'h12345678;
    latOut  = 0;
    busyOut = 0;
    while (!done && latOut < 100) begin
      if (busy) busyOut++;
      @(negedge clk);
      latOut++;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_flags", {30'd0, div_by_zero, mult_overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 7 * 6
    runOp(1'b0, 32'd7, 32'd6, lat, busyCycles);
    check("mul76_lat", lat, 32'd34);
    check("mul76_busy", busyCycles, 32'd33);
    check("mul76_hi", hi, 32'd0);
    check("mul76_lo", lo, 32'd42);
    check("mul76_ovf", {31'd0, mult_overflow}, 32'd0);
    @(negedge clk);
    check("mul76_pulse", {31'd0, done}, 32'd0);

    // -3 * 5
    runOp(1'b0, 32'hFFFFFFFD, 32'd5, lat, busyCycles);
    check("mulneg_hi", hi, 32'hFFFFFFFF);
    check("mulneg_lo", lo, 32'hFFFFFFF1);
    check("mulneg_ovf", {31'd0, mult_overflow}, 32'd0);

    // 0x10000 * 0x10000 overflows signed 32 bits
    runOp(1'b0, 32'h00010000, 32'h00010000, lat, busyCycles);
    check("mulovf_hi", hi, 32'd1);
    check("mulovf_lo", lo, 32'd0);
    check("mulovf_ovf", {31'd0, mult_overflow}, 32'd1);

    // -7 / 2 -> q=-3 r=-1 ; overflow flag cleared by the new operation
    runOp(1'b1, 32'hFFFFFFF9, 32'd2, lat, busyCycles);
    check("divn_lat", lat, 32'd34);
    check("divn_lo", lo, 32'hFFFFFFFD);
    check("divn_hi", hi, 32'hFFFFFFFF);
    check("divn_flags", {30'd0, div_by_zero, mult_overflow}, 32'd0);

    // 7 / -2 -> q=-3 r=1
    runOp(1'b1, 32'd7, 32'hFFFFFFFE, lat, busyCycles);
    check("divd_lo", lo, 32'hFFFFFFFD);
    check("divd_hi", hi, 32'd1);

    // most negative / -1
    runOp(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, busyCycles);
    check("divmin_lo", lo, 32'h80000000);
    check("divmin_hi", hi, 32'd0);
    check("divmin_flags", {30'd0, div_by_zero, mult_overflow}, 32'd0);

    // preload 0/42, then divide by zero
    runOp(1'b0, 32'd7, 32'd6, lat, busyCycles);
    runOp(1'b1, 32'd9, 32'd0, lat, busyCycles);
    check("dbz_lat", lat, 32'd1);
    check("dbz_busy", busyCycles, 32'd0);
    check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    check("dbz_ovf", {31'd0, mult_overflow}, 32'd0);
    check("dbz_hi", hi, 32'd0);
    check("dbz_lo", lo, 32'd42);
    @(negedge clk);
    check("dbz_hold", {31'd0, div_by_zero}, 32'd1);

    // Busy protection: 2*3 with stray starts at cycles 5 and 20
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd2;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("busyp_flagclr", {31'd0, div_by_zero}, 32'd0);
    lat       = 0;
    doneCount = 0;
    while (!done && lat < 100) begin
      if (lat == 5 || lat == 20) begin
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd100;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    if (done) doneCount++;
    check("busyp_lat", lat, 32'd34);
    check("busyp_lo", lo, 32'd6);
    // start in the done cycle is accepted on the next edge
    start = 1'b1;
    a     = 32'd4;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("busyp_restart", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (done) doneCount++;
    check("busyp_dones", doneCount, 32'd2);
    check("busyp_lo2", lo, 32'd20);

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    doneCount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    check("rst_nodone", doneCount, 32'd0);

    // Normal operation after reset: 100 / 7 -> q=14 r=2
    runOp(1'b1, 32'd100, 32'd7, lat, busyCycles);
    check("post_lat", lat, 32'd34);
    check("post_lo", lo, 32'd14);
    check("post_hi", hi, 32'd2);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
